// File: rtl/alu_issue_stage.sv
// Execute-stage wrapper: EX operand register feeding an external ALU, WB result register to writeback.
// Optional operand bypass at EX capture is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_lhs_sel,
  input  logic              in_rhs_sel,
  input  logic [RIDX_W-1:0] in_rs1,
  input  logic [RIDX_W-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_wen,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   alu_lhs,
  output logic [XLEN-1:0]   alu_rhs,
  input  logic [XLEN-1:0]   alu_res,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RIDX_W-1:0] wb_rd,
  output logic              wb_wen,
  output logic [XLEN-1:0]   wb_data
);

  logic              ex_valid;
  logic [3:0]        ex_op;
  logic [XLEN-1:0]   ex_lhs;
  logic [XLEN-1:0]   ex_rhs;
  logic [RIDX_W-1:0] ex_rd;
  logic              ex_wen;

  logic              wb_free;
  logic              ex_adv;
  logic              hazard;
  logic [XLEN-1:0]   lhs_next;
  logic [XLEN-1:0]   rhs_next;

  assign wb_free = !wb_valid || wb_ready;
  assign ex_adv  = ex_valid && wb_free;

`ifdef ALU_ISSUE_FWD_EN
  // A stalled EX producer already blocks intake; the explicit term keeps the hold rule local to forwarding.
  assign hazard = ex_valid && !ex_adv && ex_wen &&
                  ((!in_lhs_sel && in_rs1 != '0 && ex_rd == in_rs1) ||
                   (!in_rhs_sel && in_rs2 != '0 && ex_rd == in_rs2));
`else
  logic unused_idx;
  assign unused_idx = ^{in_rs1, in_rs2};
  assign hazard     = 1'b0;
`endif

  assign in_ready = (!ex_valid || wb_free) && !hazard;

  always_comb begin
    lhs_next = in_lhs_sel ? in_pc  : in_rs1_val;
    rhs_next = in_rhs_sel ? in_imm : in_rs2_val;
`ifdef ALU_ISSUE_FWD_EN
    if (!in_lhs_sel && in_rs1 != '0) begin
      if (ex_adv && ex_wen && ex_rd == in_rs1)
        lhs_next = alu_res;
      else if (wb_valid && wb_wen && wb_rd == in_rs1)
        lhs_next = wb_data;
    end
    if (!in_rhs_sel && in_rs2 != '0) begin
      if (ex_adv && ex_wen && ex_rd == in_rs2)
        rhs_next = alu_res;
      else if (wb_valid && wb_wen && wb_rd == in_rs2)
        rhs_next = wb_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_lhs   <= '0;
      ex_rhs   <= '0;
      ex_rd    <= '0;
      ex_wen   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_wen   <= 1'b0;
      wb_data  <= '0;
    end else begin
      if (wb_free) begin
        wb_valid <= ex_valid;
        if (ex_valid) begin
          wb_data <= alu_res;
          wb_rd   <= ex_rd;
          wb_wen  <= ex_wen && (ex_rd != '0);
        end
      end
      if (in_ready) begin
        ex_valid <= in_valid;
        if (in_valid) begin
          ex_op  <= in_op;
          ex_lhs <= lhs_next;
          ex_rhs <= rhs_next;
          ex_rd  <= in_rd;
          ex_wen <= in_wen;
        end
      end
    end
  end

  assign alu_op  = ex_op;
  assign alu_lhs = ex_lhs;
  assign alu_rhs = ex_rhs;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: architectural register-file model, external ALU, randomized backpressure.
module tb_alu_issue_stage;
  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3, OP_SLTU = 4'd4,
                         OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_OR = 4'd8, OP_AND = 4'd9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic              in_lhs_sel = 1'b0;
  logic              in_rhs_sel = 1'b0;
  logic [RIDX_W-1:0] in_rs1 = '0;
  logic [RIDX_W-1:0] in_rs2 = '0;
  logic [XLEN-1:0]   in_rs1_val = '0;
  logic [XLEN-1:0]   in_rs2_val = '0;
  logic [XLEN-1:0]   in_pc = '0;
  logic [XLEN-1:0]   in_imm = '0;
  logic [RIDX_W-1:0] in_rd = '0;
  logic              in_wen = 1'b0;
  logic [3:0]        alu_op;
  logic [XLEN-1:0]   alu_lhs;
  logic [XLEN-1:0]   alu_rhs;
  logic [XLEN-1:0]   alu_res;
  logic              wb_valid;
  logic              wb_ready = 1'b1;
  logic [RIDX_W-1:0] wb_rd;
  logic              wb_wen;
  logic [XLEN-1:0]   wb_data;

  alu_issue_stage #(.XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_lhs_sel(in_lhs_sel), .in_rhs_sel(in_rhs_sel), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_pc(in_pc), .in_imm(in_imm),
    .in_rd(in_rd), .in_wen(in_wen), .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
    .alu_res(alu_res), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_wen(wb_wen), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'b0, a < b};
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return '0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, alu_lhs, alu_rhs);

  typedef struct {
    logic [XLEN-1:0]   data;
    logic [RIDX_W-1:0] rd;
    logic              wen;
  } exp_t;

  exp_t            q[$];
  logic [XLEN-1:0] rf   [0:31];  // committed register file seen by decode
  logic [XLEN-1:0] arch [0:31];  // program-order register state
  int              checks = 0;
  int              errors = 0;
  int              mode = 0;     // 0: wb_ready=1, 1: wb_ready=0, 2: random

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    if (mode == 2) wb_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic set_mode(input int m);
    mode = m;
    if (m == 0) wb_ready = 1'b1;
    else if (m == 1) wb_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each writeback handshake and checks stall stability.
  initial begin : monitor
    exp_t            e;
    logic            stall_prev = 1'b0;
    logic [XLEN-1:0] pd = '0;
    logic [RIDX_W-1:0] prd = '0;
    logic            pwen = 1'b0;
    logic            upd;
    forever begin
      @(negedge clk);
      upd = 1'b0;
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (wb_valid !== 1'b1 || wb_data !== pd || wb_rd !== prd || wb_wen !== pwen) begin
            errors++;
            $display("FAIL stall_hold actual v=%b d=%h rd=%0d wen=%b expected v=1 d=%h rd=%0d wen=%b",
                     wb_valid, wb_data, wb_rd, wb_wen, pd, prd, pwen);
          end
        end
        if (wb_valid && wb_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected actual d=%h rd=%0d expected no output", wb_data, wb_rd);
          end else begin
            e = q.pop_front();
            if (wb_data !== e.data || wb_rd !== e.rd || wb_wen !== e.wen) begin
              errors++;
              $display("FAIL wb_result actual d=%h rd=%0d wen=%b expected d=%h rd=%0d wen=%b",
                       wb_data, wb_rd, wb_wen, e.data, e.rd, e.wen);
            end
            upd = e.wen;
          end
        end
        stall_prev = wb_valid && !wb_ready;
        pd = wb_data; prd = wb_rd; pwen = wb_wen;
      end
      @(posedge clk);
      if (upd) rf[e.rd] = e.data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic lsel, input logic rsel,
                       input logic [RIDX_W-1:0] rs1, input logic [RIDX_W-1:0] rs2,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [RIDX_W-1:0] rd, input logic wen);
    exp_t            e;
    logic [XLEN-1:0] a, b;
    bit              ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_lhs_sel = lsel; in_rhs_sel = rsel;
    in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm; in_rd = rd; in_wen = wen;
    for (int t = 0; t < 200 && !ok; t++) begin
      in_rs1_val = rf[rs1];
      in_rs2_val = rf[rs2];
      @(negedge clk);
      if (in_ready) begin
        a = lsel ? pc  : ((FWD && rs1 != 0) ? arch[rs1] : in_rs1_val);
        b = rsel ? imm : ((FWD && rs2 != 0) ? arch[rs2] : in_rs2_val);
        e.data = alu_f(op, a, b);
        e.rd   = rd;
        e.wen  = wen && (rd != 0);
        q.push_back(e);
        if (e.wen) arch[rd] = e.data;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    set_mode(0);
    for (int t = 0; t < 500 && q.size() != 0; t++) idle(1);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic setreg(input int r, input logic [XLEN-1:0] v);
    rf[r] = v;
    arch[r] = v;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 32; i++) setreg(i, (i == 0) ? '0 : $urandom);

    // Reset held two cycles with a pending instruction
    reset = 1'b1; in_valid = 1'b1; in_op = OP_ADD; in_rs1_val = 32'h1234; in_rs2_val = 32'h55;
    idle(2);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_alu_lhs", alu_lhs, 0);
    chk("rst_alu_rhs", alu_rhs, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd_wen", {wb_rd, wb_wen}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    idle(3);

    // ADD rs1_val=5 + imm 7 -> x3, two-edge latency
    setreg(1, 5);
    issue(OP_ADD, 1'b0, 1'b1, 5'd1, 5'd0, 32'd0, 32'd7, 5'd3, 1'b1);
    @(negedge clk);
    chk("lat_wb_not_yet", wb_valid, 0);
    @(negedge clk);
    chk("lat_wb_valid", wb_valid, 1);
    chk("add_data", wb_data, 12);
    chk("add_rd_wen", {wb_rd, wb_wen}, {5'd3, 1'b1});
    @(posedge clk); #1;
    drain();

    // Back-to-back SUB, SLL, SLTU
    issue(OP_SUB,  1'b1, 1'b1, 5'd0, 5'd0, 32'd10, 32'd3, 5'd4, 1'b1);
    issue(OP_SLL,  1'b1, 1'b1, 5'd0, 5'd0, 32'd1,  32'd4, 5'd5, 1'b1);
    issue(OP_SLTU, 1'b1, 1'b1, 5'd0, 5'd0, 32'd1,  32'hFFFF_FFFF, 5'd6, 1'b1);
    @(negedge clk);
    chk("b2b_sll", wb_data, 16);
    @(negedge clk);
    chk("b2b_sltu", wb_data, 1);
    @(posedge clk); #1;
    drain();

    // Backpressure: two instructions held, then drained in order
    set_mode(1);
    issue(OP_XOR, 1'b1, 1'b1, 5'd0, 5'd0, 32'hF0F0_0000, 32'h0F0F_0000, 5'd7, 1'b1);
    issue(OP_OR,  1'b1, 1'b1, 5'd0, 5'd0, 32'h0000_00A0, 32'h0000_000B, 5'd8, 1'b1);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    idle(4);
    drain();

    // rd=0 result is emitted without write enable
    issue(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 32'd1, 32'd1, 5'd0, 1'b1);
    drain();

    // Dependent pair: x5 = 2+3, then x6 = x5 + 1 with stale x5 in the register file
    setreg(5, 0);
    issue(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 32'd2, 32'd3, 5'd5, 1'b1);
    issue(OP_ADD, 1'b0, 1'b1, 5'd5, 5'd0, 32'd0, 32'd1, 5'd6, 1'b1);
    @(negedge clk);
    chk("dep_first", wb_data, 5);
    @(negedge clk);
    chk("dep_second", wb_data, FWD ? 32'd6 : 32'd1);
    @(posedge clk); #1;
    drain();

    // Reset mid-operation discards in-flight work
    set_mode(1);
    issue(OP_AND, 1'b1, 1'b1, 5'd0, 5'd0, 32'hFF, 32'h0F, 5'd9, 1'b1);
    issue(OP_SRA, 1'b1, 1'b1, 5'd0, 5'd0, 32'h8000_0000, 32'd4, 5'd10, 1'b1);
    reset = 1'b1;
    q.delete();
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) arch[i] = rf[i];
    @(negedge clk);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    set_mode(0);
    idle(4);

    // Randomized traffic with hazards on a small register window and random backpressure
    set_mode(2);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      issue(4'($urandom_range(0, 9)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    drain();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
